// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: load-size codes, the jal link
// register and the packed control fields carried through the stage.
package mem_wb_stage_pkg;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    localparam int LINK_REG = 31;

    typedef struct packed {
        logic       valid;
        logic       regWrite;
        logic       memToReg;
        logic       jal;
        logic [1:0] loadSize;
        logic       loadUnsigned;
        logic [1:0] byteOffset;
    } stageCtrl_t;

endpackage

// File: rtl/load_align.sv
// Little-endian load extraction: picks the byte or half lane addressed by
// the low address bits and sign- or zero-extends it to the datapath width.
// Word loads pass the memory word through untouched.
module load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] MemData,
    input  logic [1:0]        LoadSize,
    input  logic              LoadUnsigned,
    input  logic [1:0]        ByteOffset,
    output logic [DATA_W-1:0] LoadData
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic        extBit;

    // Lane selection and extension; half loads ignore offset bit 0
    always_comb begin
        byteVal  = MemData[7:0];
        halfVal  = MemData[15:0];
        extBit   = 1'b0;
        LoadData = MemData;
        case (ByteOffset)
            2'd0:    byteVal = MemData[7:0];
            2'd1:    byteVal = MemData[15:8];
            2'd2:    byteVal = MemData[23:16];
            default: byteVal = MemData[31:24];
        endcase
        if (ByteOffset[1]) begin
            halfVal = MemData[31:16];
        end
        if (LoadSize == LS_BYTE) begin
            extBit   = LoadUnsigned ? 1'b0 : byteVal[7];
            LoadData = {{(DATA_W-8){extBit}}, byteVal};
        end else if (LoadSize == LS_HALF) begin
            extBit   = LoadUnsigned ? 1'b0 : halfVal[15];
            LoadData = {{(DATA_W-16){extBit}}, halfVal};
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back selector feeding the register
// file, plus same-cycle bypass to decode (the register file writes on the
// clock edge, so decode would otherwise read a stale value).
// Optional retire counter output enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = mem_wb_stage_pkg::LINK_REG
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              InValid,
    input  logic              InRegWrite,
    input  logic              InMemToReg,
    input  logic              InJal,
    input  logic [1:0]        InLoadSize,
    input  logic              InLoadUnsigned,
    input  logic [1:0]        InByteOffset,
    input  logic [REG_AW-1:0] InDestReg,
    input  logic [DATA_W-1:0] InAluResult,
    input  logic [DATA_W-1:0] InMemData,
    input  logic [DATA_W-1:0] InPcOut,
    input  logic [REG_AW-1:0] ReadReg1,
    input  logic [REG_AW-1:0] ReadReg2,
    output logic              RegWrite,
    output logic              Jal,
    output logic [REG_AW-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] PcOut,
    output logic              Bypass1,
    output logic              Bypass2,
    output logic [DATA_W-1:0] BypassData1,
    output logic [DATA_W-1:0] BypassData2
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [DATA_W-1:0] RetireCount
`endif
);

    import mem_wb_stage_pkg::*;

    localparam logic [REG_AW-1:0] linkAddr = REG_AW'(LINK_REG);

    stageCtrl_t        ctrlQ;
    logic [REG_AW-1:0] destQ;
    logic [DATA_W-1:0] aluQ;
    logic [DATA_W-1:0] memQ;
    logic [DATA_W-1:0] pcQ;
    logic [DATA_W-1:0] loadWord;
    logic [DATA_W-1:0] linkValue;

    // Stage register: flush beats stall beats a fresh capture
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ctrlQ <= '0;
            destQ <= '0;
            aluQ  <= '0;
            memQ  <= '0;
            pcQ   <= '0;
        end else if (Flush) begin
            ctrlQ.valid <= 1'b0;
        end else if (!Stall) begin
            ctrlQ.valid        <= InValid;
            ctrlQ.regWrite     <= InRegWrite;
            ctrlQ.memToReg     <= InMemToReg;
            ctrlQ.jal          <= InJal;
            ctrlQ.loadSize     <= InLoadSize;
            ctrlQ.loadUnsigned <= InLoadUnsigned;
            ctrlQ.byteOffset   <= InByteOffset;
            destQ              <= InDestReg;
            aluQ               <= InAluResult;
            memQ               <= InMemData;
            pcQ                <= InPcOut;
        end
    end

    load_align #(
        .DATA_W(DATA_W)
    ) uLoadAlign (
        .MemData     (memQ),
        .LoadSize    (ctrlQ.loadSize),
        .LoadUnsigned(ctrlQ.loadUnsigned),
        .ByteOffset  (ctrlQ.byteOffset),
        .LoadData    (loadWord)
    );

    // Jal suppresses RegWrite so the link register is never written twice
    assign Jal       = ctrlQ.valid & ctrlQ.jal;
    assign RegWrite  = ctrlQ.valid & ctrlQ.regWrite & ~ctrlQ.jal & (destQ != '0);
    assign WriteReg  = destQ;
    assign WriteData = ctrlQ.memToReg ? loadWord : aluQ;
    assign PcOut     = pcQ;
    assign linkValue = pcQ + DATA_W'(1);

    // Forward the value being written this cycle to both decode read ports
    always_comb begin
        Bypass1     = 1'b0;
        Bypass2     = 1'b0;
        BypassData1 = '0;
        BypassData2 = '0;
        if (ReadReg1 != '0) begin
            if (RegWrite && (WriteReg == ReadReg1)) begin
                Bypass1     = 1'b1;
                BypassData1 = WriteData;
            end else if (Jal && (ReadReg1 == linkAddr)) begin
                Bypass1     = 1'b1;
                BypassData1 = linkValue;
            end
        end
        if (ReadReg2 != '0) begin
            if (RegWrite && (WriteReg == ReadReg2)) begin
                Bypass2     = 1'b1;
                BypassData2 = WriteData;
            end else if (Jal && (ReadReg2 == linkAddr)) begin
                Bypass2     = 1'b1;
                BypassData2 = linkValue;
            end
        end
    end

`ifdef MEM_WB_RETIRE_CNT_EN
    // Count each valid instruction as it leaves the stage; wraps naturally
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            RetireCount <= '0;
        end else if (ctrlQ.valid && !Stall && !Flush) begin
            RetireCount <= RetireCount + DATA_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage with hand-computed expected values.
// Inputs are driven 1 time unit after the rising edge and outputs are
// checked at the same point, well away from the next active edge.
module tb_mem_wb_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              Clk;
    logic              Rst_n;
    logic              Stall;
    logic              Flush;
    logic              InValid;
    logic              InRegWrite;
    logic              InMemToReg;
    logic              InJal;
    logic [1:0]        InLoadSize;
    logic              InLoadUnsigned;
    logic [1:0]        InByteOffset;
    logic [REG_AW-1:0] InDestReg;
    logic [DATA_W-1:0] InAluResult;
    logic [DATA_W-1:0] InMemData;
    logic [DATA_W-1:0] InPcOut;
    logic [REG_AW-1:0] ReadReg1;
    logic [REG_AW-1:0] ReadReg2;
    logic              RegWrite;
    logic              Jal;
    logic [REG_AW-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] PcOut;
    logic              Bypass1;
    logic              Bypass2;
    logic [DATA_W-1:0] BypassData1;
    logic [DATA_W-1:0] BypassData2;
`ifdef MEM_WB_RETIRE_CNT_EN
    logic [DATA_W-1:0] RetireCount;
`endif

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(
        .DATA_W(DATA_W),
        .REG_AW(REG_AW),
        .LINK_REG(31)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Stall         (Stall),
        .Flush         (Flush),
        .InValid       (InValid),
        .InRegWrite    (InRegWrite),
        .InMemToReg    (InMemToReg),
        .InJal         (InJal),
        .InLoadSize    (InLoadSize),
        .InLoadUnsigned(InLoadUnsigned),
        .InByteOffset  (InByteOffset),
        .InDestReg     (InDestReg),
        .InAluResult   (InAluResult),
        .InMemData     (InMemData),
        .InPcOut       (InPcOut),
        .ReadReg1      (ReadReg1),
        .ReadReg2      (ReadReg2),
        .RegWrite      (RegWrite),
        .Jal           (Jal),
        .WriteReg      (WriteReg),
        .WriteData     (WriteData),
        .PcOut         (PcOut),
        .Bypass1       (Bypass1),
        .Bypass2       (Bypass2),
        .BypassData1   (BypassData1),
        .BypassData2   (BypassData2)
`ifdef MEM_WB_RETIRE_CNT_EN
        ,
        .RetireCount   (RetireCount)
`endif
    );

    // Free-running clock, period 10
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present one MEM-stage instruction, then advance past the next edge
    task automatic applyStimulus(input logic valid, input logic regWr, input logic memToReg,
                                 input logic jal, input logic [1:0] size, input logic uns,
                                 input logic [1:0] offset, input logic [4:0] dest,
                                 input logic [31:0] alu, input logic [31:0] mem,
                                 input logic [31:0] pc);
        InValid        = valid;
        InRegWrite     = regWr;
        InMemToReg     = memToReg;
        InJal          = jal;
        InLoadSize     = size;
        InLoadUnsigned = uns;
        InByteOffset   = offset;
        InDestReg      = dest;
        InAluResult    = alu;
        InMemData      = mem;
        InPcOut        = pc;
        @(posedge Clk);
        #1;
    endtask

    // Directed sequence
    initial begin
        Rst_n    = 1'b0;
        Stall    = 1'b0;
        Flush    = 1'b0;
        ReadReg1 = '0;
        ReadReg2 = '0;
        InValid = 0; InRegWrite = 0; InMemToReg = 0; InJal = 0;
        InLoadSize = 0; InLoadUnsigned = 0; InByteOffset = 0;
        InDestReg = 0; InAluResult = 0; InMemData = 0; InPcOut = 0;

        // Reset state
        @(posedge Clk);
        #1;
        checkOutput("rst_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("rst_jal", 32'(Jal), 32'd0);
        checkOutput("rst_writereg", 32'(WriteReg), 32'd0);
        checkOutput("rst_writedata", WriteData, 32'h0);
        checkOutput("rst_pcout", PcOut, 32'h0);
        checkOutput("rst_bypass1", 32'(Bypass1), 32'd0);
        checkOutput("rst_bypassdata2", BypassData2, 32'h0);
`ifdef MEM_WB_RETIRE_CNT_EN
        checkOutput("rst_retire", RetireCount, 32'd0);
`endif
        Rst_n = 1'b1;

        // lb signed, offset 2 -> byte 0x80 sign-extended
        ReadReg1 = 5'd3;
        applyStimulus(1, 1, 1, 0, 2'b00, 0, 2'd2, 5'd3, 32'h0, 32'h1280_3456, 32'h10);
        checkOutput("lb_regwrite", 32'(RegWrite), 32'd1);
        checkOutput("lb_writereg", 32'(WriteReg), 32'd3);
        checkOutput("lb_data", WriteData, 32'hFFFF_FF80);
        checkOutput("lb_bypass1", 32'(Bypass1), 32'd1);
        checkOutput("lb_bypassdata1", BypassData1, 32'hFFFF_FF80);

        // lbu, same inputs
        applyStimulus(1, 1, 1, 0, 2'b00, 1, 2'd2, 5'd3, 32'h0, 32'h1280_3456, 32'h11);
        checkOutput("lbu_data", WriteData, 32'h0000_0080);

        // lb offset 3 and offset 0 lanes
        applyStimulus(1, 1, 1, 0, 2'b00, 0, 2'd3, 5'd3, 32'h0, 32'h1280_3456, 32'h12);
        checkOutput("lb_off3_data", WriteData, 32'h0000_0012);
        applyStimulus(1, 1, 1, 0, 2'b00, 0, 2'd0, 5'd3, 32'h0, 32'h1280_3456, 32'h13);
        checkOutput("lb_off0_data", WriteData, 32'h0000_0056);

        // lh offset 3 -> upper half 0x8001 sign-extended
        applyStimulus(1, 1, 1, 0, 2'b01, 0, 2'd3, 5'd4, 32'h0, 32'h8001_7FFF, 32'h14);
        checkOutput("lh_off3_data", WriteData, 32'hFFFF_8001);
        // lhu offset 1 -> lower half, offset bit 0 ignored
        applyStimulus(1, 1, 1, 0, 2'b01, 1, 2'd1, 5'd4, 32'h0, 32'h8001_7FFF, 32'h15);
        checkOutput("lhu_off1_data", WriteData, 32'h0000_7FFF);
        // lhu offset 2 -> upper half zero-extended
        applyStimulus(1, 1, 1, 0, 2'b01, 1, 2'd2, 5'd4, 32'h0, 32'h8001_7FFF, 32'h16);
        checkOutput("lhu_off2_data", WriteData, 32'h0000_8001);
        // lw with code 11 and nonzero offset -> full word
        applyStimulus(1, 1, 1, 0, 2'b11, 0, 2'd3, 5'd4, 32'h0, 32'hCAFE_F00D, 32'h17);
        checkOutput("lw_data", WriteData, 32'hCAFE_F00D);

        // Jal with InRegWrite set: link bypass, no RegWrite
        ReadReg1 = 5'd31;
        ReadReg2 = 5'd5;
        applyStimulus(1, 1, 0, 1, 2'b10, 0, 2'd0, 5'd31, 32'h1234, 32'h0, 32'h40);
        checkOutput("jal_jal", 32'(Jal), 32'd1);
        checkOutput("jal_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("jal_pcout", PcOut, 32'h40);
        checkOutput("jal_bypass1", 32'(Bypass1), 32'd1);
        checkOutput("jal_bypassdata1", BypassData1, 32'h41);
        checkOutput("jal_bypass2", 32'(Bypass2), 32'd0);
        checkOutput("jal_bypassdata2", BypassData2, 32'h0);

        // Jal link value wraps modulo 2^32
        applyStimulus(1, 0, 0, 1, 2'b10, 0, 2'd0, 5'd31, 32'h0, 32'h0, 32'hFFFF_FFFF);
        checkOutput("jal_wrap_bypassdata1", BypassData1, 32'h0);

        // ALU write to r0 never writes or bypasses
        ReadReg1 = 5'd7;
        ReadReg2 = 5'd0;
        applyStimulus(1, 1, 0, 0, 2'b10, 0, 2'd0, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h20);
        checkOutput("r0_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("r0_bypass2", 32'(Bypass2), 32'd0);
        checkOutput("r0_writedata", WriteData, 32'hDEAD_BEEF);

        // ALU write with port 2 match
        ReadReg2 = 5'd9;
        applyStimulus(1, 1, 0, 0, 2'b10, 0, 2'd0, 5'd9, 32'h0BAD_F00D, 32'h0, 32'h21);
        checkOutput("alu_bypass2", 32'(Bypass2), 32'd1);
        checkOutput("alu_bypassdata2", BypassData2, 32'h0BAD_F00D);
        checkOutput("alu_bypass1", 32'(Bypass1), 32'd0);

        // Invalid instruction: no write
        applyStimulus(0, 1, 0, 0, 2'b10, 0, 2'd0, 5'd9, 32'h1111_1111, 32'h0, 32'h22);
        checkOutput("inv_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("inv_bypass2", 32'(Bypass2), 32'd0);

        // Write to r5, then stall 3 cycles while the inputs change
        applyStimulus(1, 1, 0, 0, 2'b10, 0, 2'd0, 5'd5, 32'h0000_0055, 32'h0, 32'h30);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 0, 2'b10, 0, 2'd0, 5'd7, 32'h0000_0099, 32'h0, 32'h31);
            checkOutput($sformatf("stall%0d_regwrite", i), 32'(RegWrite), 32'd1);
            checkOutput($sformatf("stall%0d_writereg", i), 32'(WriteReg), 32'd5);
            checkOutput($sformatf("stall%0d_writedata", i), WriteData, 32'h55);
            checkOutput($sformatf("stall%0d_pcout", i), PcOut, 32'h30);
        end
        // Flush together with stall invalidates the stage
        Flush = 1'b1;
        applyStimulus(1, 1, 0, 1, 2'b10, 0, 2'd0, 5'd7, 32'h0000_0099, 32'h0, 32'h32);
        checkOutput("flush_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("flush_jal", 32'(Jal), 32'd0);
        Flush = 1'b0;
        Stall = 1'b0;

        // Mid-cycle asynchronous reset while a write is pending
        ReadReg1 = 5'd6;
        applyStimulus(1, 1, 0, 0, 2'b10, 0, 2'd0, 5'd6, 32'h7777_0001, 32'h0, 32'h50);
        checkOutput("pre_rst_regwrite", 32'(RegWrite), 32'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        checkOutput("async_rst_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("async_rst_writereg", 32'(WriteReg), 32'd0);
        checkOutput("async_rst_writedata", WriteData, 32'h0);
        checkOutput("async_rst_pcout", PcOut, 32'h0);
        checkOutput("async_rst_bypass1", 32'(Bypass1), 32'd0);
        checkOutput("async_rst_bypassdata1", BypassData1, 32'h0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;

`ifdef MEM_WB_RETIRE_CNT_EN
        checkOutput("retire_after_rst", RetireCount, 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 0, 0, 2'b10, 0, 2'd0, 5'd8, 32'(i), 32'h0, 32'(i));
        end
        applyStimulus(0, 0, 0, 0, 2'b10, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        checkOutput("retire_count4", RetireCount, 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
